// File: rtl/trails_pkg.sv
// trails_pkg: shared definitions for the trail writer and the trail line renderer.
//   - trail_code_e : 3-bit trail code stored per cell in the trail RAM
//   - colour constants for blue/red trails and corners
//   - play-area geometry (PLAY_SIZE pixels square, CELLS cells per side)
//   - fetch_state_e : line prefetcher FSM states
//   - norm_code / code_rgb helpers
package trails_pkg;

  typedef enum logic [2:0] {
    TC_NONE = 3'd0,
    B_HORIZ = 3'd1,
    B_VERT  = 3'd2,
    R_HORIZ = 3'd3,
    R_VERT  = 3'd4,
    CORNER  = 3'd5,
    TC_RSV6 = 3'd6,
    TC_RSV7 = 3'd7
  } trail_code_e;

  localparam logic [23:0] BLUE_RGB   = 24'h00A0FF;
  localparam logic [23:0] RED_RGB    = 24'hFF3020;
  localparam logic [23:0] CORNER_RGB = 24'hFFFFFF;

  localparam int PLAY_SIZE = 448;
  localparam int CELLS     = 112;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Reserved codes 6/7 behave as an empty cell.
  function automatic logic [2:0] norm_code(input logic [2:0] c);
    return (c > 3'd5) ? 3'd0 : c;
  endfunction

  function automatic logic [23:0] code_rgb(input logic [2:0] c);
    case (c)
      B_HORIZ, B_VERT: return BLUE_RGB;
      R_HORIZ, R_VERT: return RED_RGB;
      CORNER:          return CORNER_RGB;
      default:         return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/trail_line_render_if.sv
// trail_line_render_if: read port of the shared trail RAM, via its arbiter.
//   rd_en   : read request (master -> arbiter)
//   rd_gnt  : grant; a read is issued on a cycle with rd_en & rd_gnt
//   rd_addr : cell address row*CELLS + col
//   rd_data : trail code, valid one clock after the issuing cycle
interface trail_line_render_if;
  logic        rd_en;
  logic        rd_gnt;
  logic [13:0] rd_addr;
  logic [2:0]  rd_data;

  modport master (output rd_en, output rd_addr, input  rd_gnt, input  rd_data);
  modport slave  (input  rd_en, input  rd_addr, output rd_gnt, output rd_data);
endinterface

// File: rtl/trail_line_buf.sv
// trail_line_buf: one cell row of trail codes (CELLS x 3 bits).
//   clk          : clock
//   we/waddr/wdata : synchronous write port, driven by the prefetch FSM
//   raddr/rdata  : NRD combinational read ports (packed), used by render;
//                  addresses >= CELLS read back as code 0
// The storage has no reset: stale contents are legitimately rendered
// after an overrun, and validity is tracked by the parent.
module trail_line_buf #(
  parameter int CELLS = 112,
  parameter int NRD   = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [6:0]          waddr,
  input  logic [2:0]          wdata,
  input  logic [NRD-1:0][6:0] raddr,
  output logic [NRD-1:0][2:0] rdata
);

  logic [2:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we && (waddr < 7'(CELLS))) mem[waddr] <= wdata;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rdata[i] = (raddr[i] < 7'(CELLS)) ? mem[raddr[i]] : 3'd0;
  end

endmodule

// File: rtl/trail_line_render.sv
// trail_line_render: prefetches one cell row of trail codes from the trail
// RAM during horizontal blanking into a local line buffer, then renders
// trail pixels from that buffer during active video.
// Ports:
//   Clk, Reset      : clock, synchronous active-high reset
//   pix_ce          : pixel clock enable; DrawX/DrawY advance on pix_ce
//   DrawX, DrawY    : current pixel position
//   rd              : trail RAM read port (master modport)
//   trail_on/rgb    : registered pixel result, held between pix_ce cycles
//   fetch_busy      : prefetch in progress (FETCH or DRAIN)
//   fetch_overrun   : one-clock pulse when active video starts mid-fetch
// Build option: define TRAIL_THIN_EN for line-style trails; otherwise every
// non-zero code fills its whole 4x4 cell.
module trail_line_render #(
  parameter int X_OFF      = 14,
  parameter int Y_OFF      = 14,
  parameter int CELLS      = 112,
  parameter int CELL_SHIFT = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pix_ce,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  trail_line_render_if.master         rd,
  output logic                        trail_on,
  output logic [23:0]                 trail_rgb,
  output logic                        fetch_busy,
  output logic                        fetch_overrun
);
  import trails_pkg::*;

`ifdef TRAIL_THIN_EN
  localparam int NRD = 3;   // centre, left and right neighbour
`else
  localparam int NRD = 1;
`endif

  localparam logic [10:0] XLO      = 11'(X_OFF);
  localparam logic [10:0] XHI      = 11'(X_OFF + PLAY_SIZE);
  localparam logic [10:0] YLO      = 11'(Y_OFF);
  localparam logic [10:0] YHI      = 11'(Y_OFF + PLAY_SIZE);
  localparam logic [10:0] SUB_MASK = 11'((1 << CELL_SHIFT) - 1);
  localparam logic [6:0]  LAST_COL = 7'(CELLS - 1);

  fetch_state_e state_q, state_d;
  logic [6:0]   col_q, col_d;         // next column to issue
  logic [6:0]   row_q, row_d;
  logic         wr_pend_q, wr_pend_d; // rd_data this cycle belongs to wr_col_q
  logic [6:0]   wr_col_q, wr_col_d;
  logic         buf_valid_q, buf_valid_d;
  logic         trail_on_q, trail_on_d;
  logic [23:0]  trail_rgb_q, trail_rgb_d;
  logic         overrun_q, overrun_d;

  // Trigger: at DrawX==640 the next line L=DrawY+1 starts a new cell row.
  logic [10:0] line_nxt, line_rel, px_rel;
  logic        trig, in_play;
  logic [6:0]  trig_row, rcol;

  assign line_nxt = {1'b0, DrawY} + 11'd1;
  assign line_rel = line_nxt - YLO;
  assign trig_row = 7'(line_rel >> CELL_SHIFT);
  assign trig     = pix_ce && (DrawX == 10'd640) && (line_nxt >= YLO) &&
                    (line_nxt < YHI) && ((line_rel & SUB_MASK) == 11'd0);

  assign px_rel  = {1'b0, DrawX} - XLO;
  assign rcol    = 7'(px_rel >> CELL_SHIFT);
  assign in_play = ({1'b0, DrawX} >= XLO) && ({1'b0, DrawX} < XHI) &&
                   ({1'b0, DrawY} >= YLO) && ({1'b0, DrawY} < YHI);

  logic [NRD-1:0][6:0] raddr;
  logic [NRD-1:0][2:0] rdata;
  logic [2:0]          code;
  logic                lit;

  assign raddr[0] = rcol;
`ifdef TRAIL_THIN_EN
  // Wrap-around at col 0 / col CELLS-1 lands out of range and reads 0.
  assign raddr[1] = rcol - 7'd1;
  assign raddr[2] = rcol + 7'd1;
`endif

  trail_line_buf #(.CELLS(CELLS), .NRD(NRD)) u_buf (
    .clk   (Clk),
    .we    (wr_pend_q),
    .waddr (wr_col_q),
    .wdata (rd.rd_data),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef TRAIL_THIN_EN
  logic [1:0] sx, sy;
  logic       mid_x, mid_y, left_lit, right_lit;
  assign sx = px_rel[1:0];
  assign sy = 2'(DrawY - 10'(Y_OFF));
`endif

  always_comb begin
    code = norm_code(rdata[0]);
`ifdef TRAIL_THIN_EN
    mid_x     = (sx == 2'd1) || (sx == 2'd2);
    mid_y     = (sy == 2'd1) || (sy == 2'd2);
    left_lit  = norm_code(rdata[1]) != 3'd0;
    right_lit = norm_code(rdata[2]) != 3'd0;
    lit       = 1'b0;
    case (code)
      B_HORIZ, R_HORIZ: lit = mid_y;
      B_VERT,  R_VERT:  lit = mid_x;
      // Corner: centre 2x2, plus horizontal arms toward lit neighbours.
      CORNER: lit = mid_y && (mid_x || ((sx == 2'd0) && left_lit) ||
                                       ((sx == 2'd3) && right_lit));
      default: lit = 1'b0;
    endcase
`else
    lit = (code != 3'd0);
`endif
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wr_pend_d   = 1'b0;
    wr_col_d    = wr_col_q;
    buf_valid_d = buf_valid_q;
    trail_on_d  = trail_on_q;
    trail_rgb_d = trail_rgb_q;
    overrun_d   = pix_ce && (DrawX == 10'd0) && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_FETCH;
          col_d   = 7'd0;
          row_d   = trig_row;
        end
      end
      ST_FETCH: begin
        if (rd.rd_gnt) begin
          wr_pend_d = 1'b1;
          wr_col_d  = col_q;
          if (col_q == LAST_COL) state_d = ST_DRAIN;
          else                   col_d   = col_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        // Last word is written this cycle via wr_pend_q.
        state_d     = ST_IDLE;
        buf_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pix_ce) begin
      trail_on_d  = buf_valid_q && in_play && lit;
      trail_rgb_d = trail_on_d ? code_rgb(code) : 24'h000000;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      col_q       <= 7'd0;
      row_q       <= 7'd0;
      wr_pend_q   <= 1'b0;
      wr_col_q    <= 7'd0;
      buf_valid_q <= 1'b0;
      trail_on_q  <= 1'b0;
      trail_rgb_q <= 24'h000000;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_pend_q   <= wr_pend_d;
      wr_col_q    <= wr_col_d;
      buf_valid_q <= buf_valid_d;
      trail_on_q  <= trail_on_d;
      trail_rgb_q <= trail_rgb_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd.rd_en   = (state_q == ST_FETCH);
  assign rd.rd_addr = rd.rd_en ? (14'(row_q) * 14'(CELLS) + 14'(col_q)) : 14'd0;
  assign fetch_busy    = (state_q != ST_IDLE);
  assign fetch_overrun = overrun_q;
  assign trail_on      = trail_on_q;
  assign trail_rgb     = trail_rgb_q;

endmodule
